// File: rtl/dsram_resp_pkg.sv
// Shared constants for the data-SRAM responder: geometry, byte-enable
// patterns, FSM encodings and the byte-enable legality rule.
package dsram_resp_pkg;

  localparam int          DSRAM_ADDR_W = 12;
  localparam logic [31:0] DSRAM_BASE   = 32'h8000_0000;

  localparam logic [3:0] WE_RD = 4'b0000;
  localparam logic [3:0] WE_B0 = 4'b0001;
  localparam logic [3:0] WE_B1 = 4'b0010;
  localparam logic [3:0] WE_B2 = 4'b0100;
  localparam logic [3:0] WE_B3 = 4'b1000;
  localparam logic [3:0] WE_H0 = 4'b0011;
  localparam logic [3:0] WE_H1 = 4'b1100;
  localparam logic [3:0] WE_W  = 4'b1111;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only naturally aligned byte, halfword and word stores are legal.
  function automatic logic we_legal(input logic [3:0] we);
    case (we)
      WE_RD, WE_B0, WE_B1, WE_B2, WE_B3, WE_H0, WE_H1, WE_W: we_legal = 1'b1;
      default:                                              we_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dsram_resp_sram_bw.sv
// Single-port synchronous RAM with four byte-write enables and a registered
// read port that holds unless a read or a clear is requested.
module sram_bw #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic              i_rclr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // The output register only resets; the array is cleared by the owner's fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rdata <= '0;
    else if (i_rclr) r_rdata <= '0;
    else if (i_re)   r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dsram_resp.sv
// Data-SRAM responder: zero-fills the array after reset, then serves word
// reads/byte-masked writes with one-cycle latency and flags illegal accesses.
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int          ADDR_W    = DSRAM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = DSRAM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hold,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ready,
  output logic        acc_err,
  output state_t      o_state
);

  // Handshake: a request is taken on a rising edge when ready=1, en=1 and
  // stall_hold=0; the result (rdata or acc_err) is visible right after that edge.

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_acc_err;

  logic [ADDR_W-1:0] w_idx, w_mem_addr;
  logic [3:0]        w_mem_be;
  logic [31:0]       w_mem_wdata;
  logic              w_mem_re, w_mem_clr, w_err;
  logic              w_in_range, w_accept;
  logic              w_unused;

  assign w_idx      = data_sram_addr[ADDR_W+1:2];
  assign w_in_range = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_accept   = data_sram_en && !stall_hold;
  assign w_unused   = ^data_sram_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_addr  = w_idx;
    w_mem_be    = 4'b0000;
    w_mem_wdata = data_sram_wdata;
    w_mem_re    = 1'b0;
    w_mem_clr   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mem_addr  = r_cnt;
        w_mem_be    = WE_W;
        w_mem_wdata = '0;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept) begin
          if (!(w_in_range && we_legal(data_sram_we))) begin
            w_err     = 1'b1;
            w_mem_clr = 1'b1;
          end else if (data_sram_we == WE_RD) begin
            w_mem_re = 1'b1;
          end else begin
            w_mem_be = data_sram_we;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // acc_err freezes with rdata while MEM2 is held, otherwise it is a 1-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_acc_err <= 1'b0;
    else if (!stall_hold) r_acc_err <= w_err;
  end

  sram_bw #(.ADDR_W(ADDR_W)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (w_mem_addr),
    .i_be    (w_mem_be),
    .i_wdata (w_mem_wdata),
    .i_re    (w_mem_re),
    .i_rclr  (w_mem_clr),
    .o_rdata (data_sram_rdata)
  );

  assign ready   = (r_state == ST_RUN);
  assign acc_err = r_acc_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_dsram_resp.sv
// Bench for dsram_resp: reset/zero-fill timing, directed vector table,
// random traffic against a word-array reference model, and reset mid-fill.
module tb_dsram_resp;
  import dsram_resp_pkg::*;

  localparam int          AW    = 12;
  localparam int          DEPTH = 2**AW;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_hold = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'b0000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, acc_err;
  state_t      st;

  dsram_resp #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_hold      (stall_hold),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .ready           (ready),
    .acc_err         (acc_err),
    .o_state         (st)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain word array plus the last visible response.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rdata = '0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic m_in_range(input logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, BASE};
    hi = {1'b0, BASE} + 33'(4 * DEPTH);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic m_legal(input logic [3:0] w);
    logic [3:0] ok [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    foreach (ok[i]) if (ok[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  // One clocked step of the spec's RUN-state rules.
  task automatic model_step();
    int idx;
    if (!stall_hold) begin
      if (!en) begin
        m_err = 1'b0;
      end else if (!m_in_range(addr) || !m_legal(we)) begin
        m_rdata = '0;
        m_err   = 1'b1;
      end else begin
        idx   = int'((addr - BASE) / 4);
        m_err = 1'b0;
        if (we == 4'b0000) m_rdata = m_mem[idx];
        else for (int b = 0; b < 4; b++) if (we[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    exp_q.push_back({m_err, m_rdata});
  endtask

  // Driver: apply one request, clock it, sample 1 time unit after the edge.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic h);
    en = e; we = w; addr = a; wdata = d; stall_hold = h;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Counts edges from now until ready; INIT requests must be ignored.
  task automatic wait_ready(input string name);
    int  cyc = 0;
    logic bad = 1'b0;
    while (!ready && cyc < DEPTH + 50) begin
      @(posedge clk); #1; cyc++;
      if (!ready && (acc_err || rdata != 0)) bad = 1'b1;
    end
    en = 1'b0; we = 4'b0000; stall_hold = 1'b0;
    check({name, "_ready_cycles"}, 32'(cyc), 32'(DEPTH));
    check({name, "_init_ignored"}, 32'(bad), 32'd0);
    check({name, "_state_run"}, 32'(st), 32'(ST_RUN));
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] d, input logic h,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.en = e; v.we = w; v.addr = a; v.wdata = d; v.hold = h;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    logic [32:0] exp;
    logic [3:0]  legal_we [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [31:0] oor [4] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h9000_0000, 32'h0000_0040};
    model_clear();

    // Reset state, then zero-fill timing with an illegal request held on the bus.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_acc_err", 32'(acc_err), 32'd0);
    check("rst_state", 32'(st), 32'(ST_INIT));
    en = 1'b1; we = 4'b0101; addr = 32'h9000_0000; wdata = 32'hFFFF_FFFF;
    @(negedge clk); rst = 1'b0;
    wait_ready("init1");

    vecs.push_back(mk(1, 4'h0, 32'h8000_0010, 32'h0,         0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'hF, 32'h8000_0040, 32'hDEAD_BEEF, 0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 4'h2, 32'h8000_0040, 32'h0000_AB00, 0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         0, 32'hDEAD_ABEF, 0));
    vecs.push_back(mk(1, 4'hC, 32'h8000_0040, 32'h1234_0000, 0, 32'hDEAD_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0043, 32'h0,         0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0080, 32'h0,         1, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0080, 32'h0,         1, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0080, 32'h0,         1, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0080, 32'h0,         0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(0, 4'h0, 32'h8000_0080, 32'h0,         0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h5, 32'h8000_0040, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 4'h0, 32'h8000_0040, 32'h0,         0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h9000_0000, 32'h0,         0, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0040, 32'h0,         0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'hF, 32'h8000_3FFC, 32'hCAFE_F00D, 0, 32'h1234_ABEF, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_3FFC, 32'h0,         0, 32'hCAFE_F00D, 0));
    vecs.push_back(mk(1, 4'hF, 32'h8000_4000, 32'h5555_5555, 0, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0000, 32'h0,         0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h1, 32'h8000_0000, 32'h1111_11AA, 0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h8, 32'h8000_0000, 32'hBB22_2222, 0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 4'h0, 32'h8000_0000, 32'h0,         0, 32'hBB00_00AA, 0));

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold);
      void'(exp_q.pop_front());
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_acc_err", i), 32'(acc_err), 32'(vecs[i].exp_err));
    end

    // Random traffic over a small hot window plus a few out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      if ($urandom_range(0, 9) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) w = 4'($urandom_range(0, 15));
      else w = legal_we[$urandom_range(0, 7)];
      step($urandom_range(0, 9) < 8, w, a, $urandom, $urandom_range(0, 4) == 0);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_rdata", n), rdata, exp[31:0]);
      check($sformatf("rnd%0d_acc_err", n), 32'(acc_err), 32'(exp[32]));
    end

    // Asynchronous reset between edges clears the visible response at once.
    step(1, 4'hF, 32'h8000_0040, 32'hDEAD_BEEF, 0);
    step(1, 4'h0, 32'h8000_0040, 32'h0, 0);
    check("pre_arst_rdata", rdata, 32'hDEAD_BEEF);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_ready", 32'(ready), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset again once the fill counter has reached 100.
    repeat (100) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_init_ready", 32'(ready), 32'd0);
    check("mid_init_state", 32'(st), 32'(ST_INIT));
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk); rst = 1'b0;
    wait_ready("init2");
    step(1, 4'h0, 32'h8000_0040, 32'h0, 0);
    void'(exp_q.pop_front());
    check("refill_rdata", rdata, 32'h0);
    check("refill_acc_err", 32'(acc_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsram_resp.md
Name: dsram_resp

Overview:
- Data-SRAM responder: the memory end of the data_sram request/response interface driven by the MEM1 stage and consumed by MEM2.
- Accepts word-addressed requests with byte write enables and returns the full 32-bit read word one cycle later. MEM2 performs the byte/halfword extraction.
- Holds its read data while the MEM2 pipeline register is stalled.
- Zero-fills its array after reset and reports illegal accesses.

Parameters:
- ADDR_W, 12, word-index width; array depth is 2**ADDR_W words (16 KiB at default).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to 4*2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_hold  in  1  MEM2 register hold (pipeline stall[5]); freezes the response.
- data_sram_en  in  1  request valid.
- data_sram_we  in  4  byte write enables; 4'b0000 with en=1 means read.
- data_sram_addr  in  32  byte address; bits [1:0] are ignored.
- data_sram_wdata  in  32  write data, already lane-aligned by the requester.
- data_sram_rdata  out  32  read word, registered.
- ready  out  1  0 during post-reset zero-fill; the core must stall fetch/MEM1 while it is 0.
- acc_err  out  1  registered 1-cycle flag, aligned with data_sram_rdata timing.

Behaviour:
- Reset values: data_sram_rdata=0, ready=0, acc_err=0, state=INIT, fill counter=0. Array contents are undefined until INIT completes.
- Reset is asynchronous. Assertion mid-INIT or mid-RUN returns immediately to INIT with the counter at 0. Zero-fill restarts from word 0.
- INIT state:
  - Writes 32'h0 to word[cnt] each cycle; cnt increments.
  - After writing word 2**ADDR_W-1, next state is RUN and ready=1 from that edge on. INIT therefore lasts exactly 2**ADDR_W cycles.
  - Requests are ignored; rdata holds 0 and acc_err stays 0.
- RUN state: a request is accepted at edge N iff en=1 and stall_hold=0.
- Index and range check:
  - idx = addr[ADDR_W+1:2].
  - in_range = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
- Legal we patterns: 0000 (read), 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Accepted read (we=0000, in_range): data_sram_rdata <= word[idx] at edge N; visible from N until the next accepted read. Latency is 1 cycle.
- Accepted write (legal non-zero we, in_range):
  - Only enabled bytes of word[idx] are updated with the matching wdata lanes.
  - data_sram_rdata is unchanged.
  - A read of the same idx in cycle N+1 returns the merged word; there is no stale-data window.
- Illegal access (out of range or illegal we pattern, en=1, stall_hold=0):
  - No array write.
  - data_sram_rdata <= 0.
  - acc_err <= 1 for exactly one cycle.
- acc_err is cleared on every other clocked cycle, except while stall_hold=1, when it holds like rdata.
- stall_hold=1: data_sram_rdata and acc_err hold their values; no read, write, or error is accepted. MEM1 re-presents the same request after release, so it is applied exactly once.
- en=0: no array activity; data_sram_rdata holds.
- Single port: one operation per cycle, and a write never returns read data in the same cycle.
- Address wrap: there is no wrap. Addresses beyond the top word are out of range and flagged, never aliased.

Decomposition:
- Shared package (define.vh):
  - DSRAM_ADDR_W default.
  - DSRAM_BASE.
  - Byte-enable pattern constants: WE_B0..WE_B3, WE_H0, WE_H1, WE_W.
  - INIT/RUN state encodings.
- One sub-module, sram_bw: single-port synchronous RAM with 4 byte-write enables and a registered read output. dsram_resp owns the FSM, fill counter, legality/range check, hold muxing and acc_err.

Test Plan:
- Reset, then count cycles -> ready rises exactly 2**ADDR_W cycles after rst deassert; a read of 0x8000_0010 then returns 32'h0.
- Write 32'hDEAD_BEEF we=1111 @0x8000_0040, next cycle read -> rdata=32'hDEAD_BEEF on the cycle after the read request.
- Then write wdata=32'h0000_AB00 we=0010 @0x8000_0040, read -> 32'hDEAD_ABEF. Then we=1100 wdata=32'h1234_0000 -> 32'h1234_ABEF.
- Read returns 32'h1234_ABEF; hold stall_hold=1 for 3 cycles while requesting a read of a zeroed word -> rdata stays 32'h1234_ABEF throughout, then shows 32'h0 one cycle after release.
- we=0101 @0x8000_0040 -> acc_err pulses one cycle, rdata=0, and a later read still gives 32'h1234_ABEF. Read @0x9000_0000 -> acc_err pulse, rdata=0.
- Assert rst at fill counter=100 during INIT -> ready stays 0, INIT restarts, and ready rises 2**ADDR_W cycles after the second deassert.
